// File: rtl/signed_seq_divider.sv
// Iterative signed divider: restoring shift-subtract on magnitudes, one quotient
// bit per enabled clock, followed by a sign/flag fix-up cycle.
module signed_seq_divider #(
    parameter int DW = 36,
    parameter int VW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          ovf
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Dividend magnitude shifts out the top while quotient bits shift in at the
    // bottom. Unsigned DW bits already hold 2^(DW-1), the magnitude of the most
    // negative dividend.
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW-1:0] prem_q, prem_d;
    logic          neg_dvd_q, neg_dvd_d;
    logic          neg_dvs_q, neg_dvs_d;
    logic          dz_q, dz_d;
    logic          ovfp_q, ovfp_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dzo_q, dzo_d;
    logic          ovo_q, ovo_d;

    logic [VW:0]   shifted, diff;
    logic          qbit;

    // Partial remainder stays below |divisor| <= 2^(VW-1), so the shifted value
    // fits VW bits and the trial difference needs only one extra sign bit.
    assign shifted = {prem_q, dvd_q[DW-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign qbit    = ~diff[VW];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;
        dz_d      = dz_q;
        ovfp_d    = ovfp_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dzo_d     = dzo_q;
        ovo_d     = ovo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d     = dividend[DW-1] ? -dividend : dividend;
                    dvs_d     = divisor[VW-1]  ? -divisor  : divisor;
                    neg_dvd_d = dividend[DW-1];
                    neg_dvs_d = divisor[VW-1];
                    dz_d      = (divisor == '0);
                    ovfp_d    = (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
                    prem_d    = '0;
                    cnt_d     = '0;
                    state_d   = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                prem_d = qbit ? diff[VW-1:0] : shifted[VW-1:0];
                dvd_d  = {dvd_q[DW-2:0], qbit};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(DW-1))
                    state_d = FIX;
            end
            FIX: begin
                if (dz_q) begin
                    quo_d = '0;
                    rem_d = '0;
                    dzo_d = 1'b1;
                    ovo_d = 1'b0;
                end else begin
                    // -2^(DW-1)/-1 lands here with magnitude 2^(DW-1), which
                    // reads back as -2^(DW-1): the required wrap.
                    quo_d = (neg_dvd_q ^ neg_dvs_q) ? -dvd_q : dvd_q;
                    rem_d = neg_dvd_q ? -prem_q : prem_q;
                    dzo_d = 1'b0;
                    ovo_d = ovfp_q;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            dz_q      <= 1'b0;
            ovfp_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dzo_q     <= 1'b0;
            ovo_q     <= 1'b0;
        end else if (ce) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dvs_q <= neg_dvs_d;
            dz_q      <= dz_d;
            ovfp_q    <= ovfp_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dzo_q     <= dzo_d;
            ovo_q     <= ovo_d;
        end
    end

    assign busy        = (state_q == CALC) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dzo_q;
    assign ovf         = ovo_q;

endmodule
